// File: rtl/pwm_update_ctrl.sv
// PWM period/config update controller: double-buffered config, period counter.
// Optional `PWM_RAMP_EN: Compare slews toward its target by RampStep per period.
module pwm_update_ctrl #(
  parameter int LevelCount = 2,
  parameter int BIT_WIDTH  = 16
) (
  input  logic                  MClk,
  input  logic                  RstN,
  input  logic                  Start,
  input  logic                  Stop,
  input  logic                  CfgValid,
  output logic                  CfgReady,
  input  logic [BIT_WIDTH-1:0]  CfgCompare,
  input  logic [BIT_WIDTH-1:0]  CfgMaxCount,
  input  logic [BIT_WIDTH-1:0]  CfgStepSize,
  input  logic [BIT_WIDTH-1:0]  CfgDeadTime,
  input  logic [BIT_WIDTH-1:0]  RampStep,
  output logic [BIT_WIDTH-1:0]  Compare,
  output logic [BIT_WIDTH-1:0]  PWMMaxCount,
  output logic [BIT_WIDTH-1:0]  TriangleStepSize,
  output logic [BIT_WIDTH-1:0]  DeadTimeCount,
  output logic [LevelCount-1:0] RunLevels,
  output logic                  PeriodStart,
  output logic                  CfgCommit,
  output logic                  Running
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP_PEND
  } state_t;

  localparam logic [BIT_WIDTH-1:0] One = 1;

  state_t               state;
  state_t               state_nxt;
  logic [BIT_WIDTH-1:0] period_cnt;
  logic                 slot_full;
  logic                 committed;
  logic [BIT_WIDTH-1:0] slot_cmp;
  logic [BIT_WIDTH-1:0] slot_max;
  logic [BIT_WIDTH-1:0] slot_step;
  logic [BIT_WIDTH-1:0] slot_dead;
  logic                 active;
  logic                 last_cnt;
  logic                 fill;
  logic                 commit;
  logic [BIT_WIDTH-1:0] cmp_clamped;
  logic [BIT_WIDTH-1:0] cmp_nxt;

  assign active      = (state != IDLE);
  assign last_cnt    = (period_cnt == PWMMaxCount);
  assign CfgReady    = ~slot_full;
  assign fill        = CfgValid & ~slot_full;
  // In IDLE the slot drains at once; while running only at a period boundary.
  assign commit      = slot_full & (~active | last_cnt);
  assign cmp_clamped = (slot_cmp > slot_max) ? slot_max : slot_cmp;
  assign PeriodStart = active & (period_cnt == '0);
  assign Running     = active;
  assign RunLevels   = {LevelCount{active}};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (Start && !Stop && committed) state_nxt = RUN;
      RUN:       if (Stop) state_nxt = STOP_PEND;
      STOP_PEND: if (last_cnt) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

`ifdef PWM_RAMP_EN
  logic [BIT_WIDTH-1:0] target;
  logic [BIT_WIDTH-1:0] ramp_goal;
  logic [BIT_WIDTH-1:0] ramp_next;
  logic [BIT_WIDTH-1:0] dist;
  logic                 down;

  assign ramp_goal = commit ? cmp_clamped : target;
  assign down      = (Compare > ramp_goal);

  always_comb begin
    dist      = down ? (Compare - ramp_goal) : (ramp_goal - Compare);
    ramp_next = ramp_goal;
    if (RampStep != '0 && dist > RampStep)
      ramp_next = down ? (Compare - RampStep) : (Compare + RampStep);
  end

  // Steps land on the boundary edge so each period sees one stable value.
  always_comb begin
    cmp_nxt = Compare;
    if (commit && !active)
      cmp_nxt = cmp_clamped;
    else if (active && last_cnt)
      cmp_nxt = ramp_next;
  end

  always_ff @(posedge MClk) begin
    if (!RstN)
      target <= '0;
    else if (commit)
      target <= cmp_clamped;
  end
`else
  logic ramp_unused;

  assign ramp_unused = ^RampStep;

  always_comb begin
    cmp_nxt = Compare;
    if (commit)
      cmp_nxt = cmp_clamped;
  end
`endif

  always_ff @(posedge MClk) begin
    if (!RstN) begin
      state            <= IDLE;
      period_cnt       <= '0;
      slot_full        <= 1'b0;
      committed        <= 1'b0;
      slot_cmp         <= '0;
      slot_max         <= '0;
      slot_step        <= '0;
      slot_dead        <= '0;
      Compare          <= '0;
      PWMMaxCount      <= '1;
      TriangleStepSize <= '0;
      DeadTimeCount    <= '0;
      CfgCommit        <= 1'b0;
    end else begin
      state     <= state_nxt;
      CfgCommit <= commit;
      Compare   <= cmp_nxt;
      if (!active || last_cnt)
        period_cnt <= '0;
      else
        period_cnt <= period_cnt + One;
      if (commit) begin
        slot_full        <= 1'b0;
        committed        <= 1'b1;
        PWMMaxCount      <= slot_max;
        TriangleStepSize <= slot_step;
        DeadTimeCount    <= slot_dead;
      end else if (fill) begin
        slot_full <= 1'b1;
        slot_cmp  <= CfgCompare;
        slot_max  <= CfgMaxCount;
        slot_step <= CfgStepSize;
        slot_dead <= CfgDeadTime;
      end
    end
  end

endmodule
